alarm_bank: RTL
===============

// Module: alarm_bank
// PURPOSE
// Multi-slot alarm store and ring controller for the clock design. Holds N_ALARMS
// hh:mm:ss alarm settings, edited one field at a time with correct modulo wrap and
// optional carry/borrow. Compares enabled slots against the running time once per
// second and drives a ring / snooze / dismiss state machine with timeouts.
// PARAMETERS
// N_ALARMS    4    number of alarm slots (>=1); IW = max(1,$clog2(N_ALARMS))
// HOURS       24   hour modulus (12..24); hour field 0..HOURS-1
// CARRY       1    1: sec/min wrap carries/borrows into next field; 0: fields wrap alone
// SNOOZE_SEC  300  snooze length in sec_tick periods (>=1)
// RING_SEC    60   ring auto-timeout in sec_tick periods (>=1)
// MAX_SNOOZE  3    snoozes allowed per alarm event; further snooze acts as dismiss
// PORTS
// clk         in   1   system clock, all state on rising edge
// RESET       in   1   reset, synchronous, active-low
// sel         in   IW  slot selected for edit/readback
// field       in   2   00 sec, 01 min, 10 hour, 11 none
// inc / dec   in   1   one-cycle edit pulses on selected slot/field
// en_toggle   in   1   one-cycle pulse: invert enable of selected slot
// cur_sec/min in   6   running time seconds/minutes, binary 0..59
// cur_hr      in   5   running time hours, binary 0..HOURS-1
// sec_tick    in   1   one-cycle strobe, once per second, after cur_* updated
// snooze      in   1   one-cycle pulse
// dismiss     in   1   one-cycle pulse
// rd_sec/min  out  6   selected slot sec/min (combinational from sel)
// rd_hr       out  5   selected slot hours (combinational from sel)
// alarm_en    out  N_ALARMS  registered enable bits
// ring        out  1   registered, high in RINGING only
// ring_id     out  IW  slot that caused current event; holds last value in IDLE
// BEHAVIOUR
// - Reset (RESET=0 at clk edge): all slot times 0:00:00, alarm_en=0, state IDLE,
//   ring=0, ring_id=0, timers and snooze count 0. Overrides all other inputs.
// - Edit: inc&dec same cycle or field=11 -> no change. Edits apply next edge.
//   inc: sec 59->0, min 59->0, hr HOURS-1->0; dec: 0->59 / 0->HOURS-1.
//   CARRY=1: sec wrap also inc/dec min (and min wrap inc/dec hr, wrapping);
//   min edit wraps into hr likewise; hr never carries. CARRY=0: no carry.
// - Edits and en_toggle allowed in any state; do not alter current ring state,
//   except toggling off the slot = ring_id while RINGING/SNOOZE -> IDLE.
// - Match evaluated only on sec_tick cycle: slot enabled and time == cur_*.
//   In IDLE: lowest-index matching slot -> ring_id, state RINGING, ring=1 on the
//   edge after the sec_tick edge (1-cycle latency). Matches in RINGING/SNOOZE dropped.
// - FSM IDLE -> RINGING (match): load ring timer RING_SEC, snooze count 0.
//   RINGING: dismiss -> IDLE; else snooze -> SNOOZE if count<MAX_SNOOZE (count+1,
//   load snooze timer SNOOZE_SEC) else -> IDLE; else sec_tick decrements ring timer,
//   1->0 -> IDLE (timeout). dismiss beats snooze when simultaneous.
//   SNOOZE: dismiss -> IDLE; sec_tick decrements snooze timer, 1->0 -> RINGING with
//   ring timer reloaded RING_SEC, same ring_id. snooze pulse in SNOOZE ignored.
// - Timer width $clog2(max(SNOOZE_SEC,RING_SEC)+1); no underflow, never decrements 0.
// - Out-of-range sel (>=N_ALARMS): edits/toggle ignored, rd_* = 0.
// TESTING
// - Reset: drive RESET=0 mid-RINGING -> next edge ring=0, alarm_en=0, rd_* = 0:00:00.
// - Wrap/carry CARRY=1: slot0=00:59:59, inc sec -> 01:00:00; dec sec -> 00:59:59;
//   hr=23 inc hr -> 0, min unchanged. CARRY=0: 00:00:59 inc sec -> 00:00:00.
// - Match priority: slots 1,2 enabled at 07:30:00, slot0 disabled at same time;
//   cur=07:30:00 + sec_tick -> ring=1 next cycle, ring_id=1.
// - Timeout: RING_SEC=3, ring, 3 sec_ticks no input -> ring=0 after third tick.
// - Snooze limit: SNOOZE_SEC=2, MAX_SNOOZE=1: snooze -> ring=0, 2 ticks -> ring=1;
//   second snooze -> IDLE, no re-ring after further ticks.
// - Simultaneous snooze+dismiss while RINGING -> IDLE; toggle enable off of ringing
//   slot -> ring=0 next edge; inc+dec together -> time unchanged.

Source files
------------

// File: rtl/alarm_bank.sv
`default_nettype none
// ============================================================================
// Module   : alarm_bank
// Purpose  : Multi-slot hh:mm:ss alarm store with field editing and a
//            ring / snooze / dismiss controller driven by a 1 Hz strobe.
// Revision : 1.0  initial release
// ============================================================================
module alarm_bank #(
    parameter int N_ALARMS   = 4,
    parameter int HOURS      = 24,
    parameter int CARRY      = 1,
    parameter int SNOOZE_SEC = 300,
    parameter int RING_SEC   = 60,
    parameter int MAX_SNOOZE = 3,
    localparam int IW = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
    input  logic                clk,
    input  logic                RESET,
    input  logic [IW-1:0]       sel,
    input  logic [1:0]          field,
    input  logic                inc,
    input  logic                dec,
    input  logic                en_toggle,
    input  logic [5:0]          cur_sec,
    input  logic [5:0]          cur_min,
    input  logic [4:0]          cur_hr,
    input  logic                sec_tick,
    input  logic                snooze,
    input  logic                dismiss,
    output logic [5:0]          rd_sec,
    output logic [5:0]          rd_min,
    output logic [4:0]          rd_hr,
    output logic [N_ALARMS-1:0] alarm_en,
    output logic                ring,
    output logic [IW-1:0]       ring_id
);

    localparam int TMAX = (SNOOZE_SEC > RING_SEC) ? SNOOZE_SEC : RING_SEC;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int CW   = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;

    localparam logic [5:0]    c_MS_MAX    = 6'd59;
    localparam logic [4:0]    c_HR_MAX    = 5'(HOURS - 1);
    localparam logic [TW-1:0] c_RING_LOAD = TW'(RING_SEC);
    localparam logic [TW-1:0] c_SNZ_LOAD  = TW'(SNOOZE_SEC);
    localparam logic [TW-1:0] c_T_ONE     = TW'(1);
    localparam logic [CW-1:0] c_MAX_SNZ   = CW'(MAX_SNOOZE);
    localparam logic [CW-1:0] c_C_ONE     = CW'(1);
    localparam logic          c_CARRY     = (CARRY != 0);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RINGING = 2'd1,
        S_SNOOZE  = 2'd2
    } state_t;

    logic [5:0]          r_sec [N_ALARMS];
    logic [5:0]          r_min [N_ALARMS];
    logic [4:0]          r_hr  [N_ALARMS];
    logic [N_ALARMS-1:0] r_en;

    state_t              r_state, w_state_nxt;
    logic [TW-1:0]       r_timer, w_timer_nxt;
    logic [CW-1:0]       r_scnt, w_scnt_nxt;
    logic [IW-1:0]       r_ring_id, w_ring_id_nxt;
    logic                r_ring;

    logic [N_ALARMS-1:0] w_hit;
    logic [N_ALARMS-1:0] w_match;
    logic [IW-1:0]       w_match_id;
    logic                w_any_match;
    logic                w_sel_ok;
    logic                w_sel_en;
    logic                w_edit;
    logic                w_tog_off;
    logic [5:0]          w_rsec, w_rmin, w_nsec, w_nmin;
    logic [4:0]          w_rhr, w_nhr;
    logic                w_min_up, w_min_dn, w_hr_up, w_hr_dn;

    // One-hot slot decode; an out-of-range sel decodes to no slot at all.
    for (genvar gi = 0; gi < N_ALARMS; gi++) begin : g_dec
        assign w_hit[gi]   = (sel == IW'(gi));
        assign w_match[gi] = r_en[gi] && (r_sec[gi] == cur_sec) &&
                             (r_min[gi] == cur_min) && (r_hr[gi] == cur_hr);
    end

    assign w_sel_ok    = |w_hit;
    assign w_sel_en    = |(r_en & w_hit);
    assign w_any_match = |w_match;
    assign w_edit      = w_sel_ok && (inc ^ dec) && (field != 2'b11);
    assign w_tog_off   = en_toggle && w_sel_en && (sel == r_ring_id);

    always_comb begin
        w_rsec = '0;
        w_rmin = '0;
        w_rhr  = '0;
        for (int i = 0; i < N_ALARMS; i++) begin
            if (w_hit[i]) begin
                w_rsec = r_sec[i];
                w_rmin = r_min[i];
                w_rhr  = r_hr[i];
            end
        end
    end

    always_comb begin
        w_match_id = '0;
        for (int i = N_ALARMS - 1; i >= 0; i--) begin
            if (w_match[i]) w_match_id = IW'(i);
        end
    end

    // Field edit with ripple: sec wrap may step min, min wrap may step hr.
    always_comb begin
        w_nsec   = w_rsec;
        w_nmin   = w_rmin;
        w_nhr    = w_rhr;
        w_min_up = 1'b0;
        w_min_dn = 1'b0;
        w_hr_up  = 1'b0;
        w_hr_dn  = 1'b0;
        if (w_edit) begin
            case (field)
                2'b00: begin
                    if (inc) begin
                        if (w_rsec == c_MS_MAX) begin
                            w_nsec   = '0;
                            w_min_up = c_CARRY;
                        end else begin
                            w_nsec = w_rsec + 6'd1;
                        end
                    end else begin
                        if (w_rsec == 6'd0) begin
                            w_nsec   = c_MS_MAX;
                            w_min_dn = c_CARRY;
                        end else begin
                            w_nsec = w_rsec - 6'd1;
                        end
                    end
                end
                2'b01: begin
                    w_min_up = inc;
                    w_min_dn = dec;
                end
                2'b10: begin
                    w_hr_up = inc;
                    w_hr_dn = dec;
                end
                default: ;
            endcase
        end
        if (w_min_up) begin
            if (w_rmin == c_MS_MAX) begin
                w_nmin  = '0;
                w_hr_up = c_CARRY;
            end else begin
                w_nmin = w_rmin + 6'd1;
            end
        end else if (w_min_dn) begin
            if (w_rmin == 6'd0) begin
                w_nmin  = c_MS_MAX;
                w_hr_dn = c_CARRY;
            end else begin
                w_nmin = w_rmin - 6'd1;
            end
        end
        if (w_hr_up) begin
            w_nhr = (w_rhr == c_HR_MAX) ? 5'd0 : w_rhr + 5'd1;
        end else if (w_hr_dn) begin
            w_nhr = (w_rhr == 5'd0) ? c_HR_MAX : w_rhr - 5'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!RESET) begin
            for (int i = 0; i < N_ALARMS; i++) begin
                r_sec[i] <= '0;
                r_min[i] <= '0;
                r_hr[i]  <= '0;
            end
            r_en <= '0;
        end else begin
            for (int i = 0; i < N_ALARMS; i++) begin
                if (w_hit[i] && w_edit) begin
                    r_sec[i] <= w_nsec;
                    r_min[i] <= w_nmin;
                    r_hr[i]  <= w_nhr;
                end
                if (w_hit[i] && en_toggle) r_en[i] <= ~r_en[i];
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_timer_nxt   = r_timer;
        w_scnt_nxt    = r_scnt;
        w_ring_id_nxt = r_ring_id;
        case (r_state)
            S_IDLE: begin
                if (sec_tick && w_any_match) begin
                    w_state_nxt   = S_RINGING;
                    w_timer_nxt   = c_RING_LOAD;
                    w_scnt_nxt    = '0;
                    w_ring_id_nxt = w_match_id;
                end
            end
            S_RINGING: begin
                if (w_tog_off || dismiss) begin
                    w_state_nxt = S_IDLE;
                end else if (snooze) begin
                    if (r_scnt < c_MAX_SNZ) begin
                        w_state_nxt = S_SNOOZE;
                        w_scnt_nxt  = r_scnt + c_C_ONE;
                        w_timer_nxt = c_SNZ_LOAD;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else if (sec_tick && (r_timer != '0)) begin
                    w_timer_nxt = r_timer - c_T_ONE;
                    if (r_timer == c_T_ONE) w_state_nxt = S_IDLE;
                end
            end
            S_SNOOZE: begin
                if (w_tog_off || dismiss) begin
                    w_state_nxt = S_IDLE;
                end else if (sec_tick && (r_timer != '0)) begin
                    if (r_timer == c_T_ONE) begin
                        w_state_nxt = S_RINGING;
                        w_timer_nxt = c_RING_LOAD;
                    end else begin
                        w_timer_nxt = r_timer - c_T_ONE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!RESET) begin
            r_state   <= S_IDLE;
            r_timer   <= '0;
            r_scnt    <= '0;
            r_ring_id <= '0;
            r_ring    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_timer   <= w_timer_nxt;
            r_scnt    <= w_scnt_nxt;
            r_ring_id <= w_ring_id_nxt;
            r_ring    <= (w_state_nxt == S_RINGING);
        end
    end

    assign rd_sec   = w_rsec;
    assign rd_min   = w_rmin;
    assign rd_hr    = w_rhr;
    assign alarm_en = r_en;
    assign ring     = r_ring;
    assign ring_id  = r_ring_id;

endmodule
`default_nettype wire
